// File: rtl/fdtd_reg_bank.sv
// FDTD accelerator control/status register bank and step sequencer.
// Define FDTD_REG_BANK_IRQ_EN to store IRQ_EN and drive irq_o.
module fdtd_reg_bank #(
  parameter int unsigned AXI4_DATA_WIDTH = 32,
  parameter int unsigned WORD_ADDR_WIDTH = 4,
  parameter logic [31:0] BLOCK_ID = 32'hFD7D_0001
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         rd_avalid_i,
  input  logic [WORD_ADDR_WIDTH-1:0]   rd_word_addr_i,
  output logic [AXI4_DATA_WIDTH-1:0]   rd_data_o,
  input  logic                         wr_avalid_i,
  input  logic [WORD_ADDR_WIDTH-1:0]   wr_word_addr_i,
  input  logic [AXI4_DATA_WIDTH-1:0]   wr_data_i,
  input  logic [AXI4_DATA_WIDTH/8-1:0] wr_strb_i,
  output logic [AXI4_DATA_WIDTH-1:0]   ex_base_o,
  output logic [AXI4_DATA_WIDTH-1:0]   hy_base_o,
  output logic [AXI4_DATA_WIDTH-1:0]   nx_o,
  output logic [AXI4_DATA_WIDTH-1:0]   coeff_o,
  output logic                         step_start_o,
  input  logic                         step_done_i,
  output logic                         busy_o,
  output logic                         irq_o
);

  localparam int DW = AXI4_DATA_WIDTH;
  localparam int SW = AXI4_DATA_WIDTH / 8;
  localparam int AW = WORD_ADDR_WIDTH;

  localparam logic [AW-1:0] A_CTRL  = AW'(0);
  localparam logic [AW-1:0] A_STAT  = AW'(1);
  localparam logic [AW-1:0] A_EXB   = AW'(2);
  localparam logic [AW-1:0] A_HYB   = AW'(3);
  localparam logic [AW-1:0] A_NX    = AW'(4);
  localparam logic [AW-1:0] A_NSTEP = AW'(5);
  localparam logic [AW-1:0] A_COEFF = AW'(6);
  localparam logic [AW-1:0] A_CYC   = AW'(7);
  localparam logic [AW-1:0] A_STEP  = AW'(8);
  localparam logic [AW-1:0] A_ID    = AW'(9);

  localparam logic [DW-1:0] ONE = DW'(1);

  typedef enum logic [1:0] {
    IDLE,
    STEP_START,
    STEP_WAIT
  } state_t;

  state_t state;

  logic [DW-1:0] ex_base, hy_base, nx, nsteps, coeff;
  logic [DW-1:0] cycle_cnt, step_cnt, step_nxt;
  logic          busy, step_start, done, err;
  logic          irq_en_rd;

  logic wr_ctrl, wr_stat, wr_cfg;
  logic start_w, abort_w, run_req;
  logic clr_done, clr_err, set_done, set_err;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] d,
    input logic [SW-1:0] s
  );
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++)
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // CTRL/STATUS action bits live in byte 0 and need its strobe
  assign wr_ctrl = wr_avalid_i && (wr_word_addr_i == A_CTRL) && wr_strb_i[0];
  assign wr_stat = wr_avalid_i && (wr_word_addr_i == A_STAT) && wr_strb_i[0];
  assign wr_cfg  = wr_avalid_i && (wr_word_addr_i >= A_EXB)
                   && (wr_word_addr_i <= A_COEFF);

  assign start_w  = wr_ctrl && wr_data_i[0];
  assign abort_w  = wr_ctrl && wr_data_i[2];
  assign run_req  = start_w && !abort_w;
  assign clr_done = wr_stat && wr_data_i[1];
  assign clr_err  = wr_stat && wr_data_i[2];
  assign step_nxt = step_cnt + ONE;

  assign set_done =
    ((state == IDLE) && run_req && (nsteps == '0)) ||
    ((state == STEP_WAIT) && !abort_w && step_done_i && (step_nxt == nsteps));

  assign set_err =
    (busy && wr_cfg) ||
    (busy && run_req) ||
    (step_done_i && (state != STEP_WAIT));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      step_start <= 1'b0;
      step_cnt   <= '0;
      cycle_cnt  <= '0;
    end else begin
      step_start <= 1'b0;
      if ((state != IDLE) && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + ONE;
      if (busy && abort_w) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (run_req) begin
              step_cnt  <= '0;
              cycle_cnt <= '0;
              if (nsteps != '0) begin
                state      <= STEP_START;
                busy       <= 1'b1;
                step_start <= 1'b1;
              end
            end
          end
          STEP_START: state <= STEP_WAIT;
          STEP_WAIT: begin
            if (step_done_i) begin
              step_cnt <= step_nxt;
              if (step_nxt == nsteps) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state      <= STEP_START;
                step_start <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ex_base <= '0;
      hy_base <= '0;
      nx      <= '0;
      nsteps  <= '0;
      coeff   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (wr_cfg && !busy) begin
        unique case (1'b1)
          wr_word_addr_i == A_EXB:
            ex_base <= merge(ex_base, wr_data_i, wr_strb_i);
          wr_word_addr_i == A_HYB:
            hy_base <= merge(hy_base, wr_data_i, wr_strb_i);
          wr_word_addr_i == A_NX:
            nx <= merge(nx, wr_data_i, wr_strb_i);
          wr_word_addr_i == A_NSTEP:
            nsteps <= merge(nsteps, wr_data_i, wr_strb_i);
          default:
            coeff <= merge(coeff, wr_data_i, wr_strb_i);
        endcase
      end
      // a set in the same cycle as a clear wins
      done <= set_done || (done && !clr_done);
      err  <= set_err || (err && !clr_err);
    end
  end

`ifdef FDTD_REG_BANK_IRQ_EN
  logic irq_en, irq_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= wr_data_i[1];
      irq_q <= done && irq_en;
    end
  end

  assign irq_en_rd = irq_en;
  assign irq_o     = irq_q;
`else
  assign irq_en_rd = 1'b0;
  assign irq_o     = 1'b0;
`endif

  always_comb begin
    rd_data_o = '0;
    if (rd_avalid_i) begin
      unique case (1'b1)
        rd_word_addr_i == A_CTRL:  rd_data_o[1] = irq_en_rd;
        rd_word_addr_i == A_STAT:  rd_data_o[2:0] = {err, done, busy};
        rd_word_addr_i == A_EXB:   rd_data_o = ex_base;
        rd_word_addr_i == A_HYB:   rd_data_o = hy_base;
        rd_word_addr_i == A_NX:    rd_data_o = nx;
        rd_word_addr_i == A_NSTEP: rd_data_o = nsteps;
        rd_word_addr_i == A_COEFF: rd_data_o = coeff;
        rd_word_addr_i == A_CYC:   rd_data_o = cycle_cnt;
        rd_word_addr_i == A_STEP:  rd_data_o = step_cnt;
        rd_word_addr_i == A_ID:    rd_data_o = DW'(BLOCK_ID);
        default:                   rd_data_o = '0;
      endcase
    end
  end

  assign ex_base_o    = ex_base;
  assign hy_base_o    = hy_base;
  assign nx_o         = nx;
  assign coeff_o      = coeff;
  assign step_start_o = step_start;
  assign busy_o       = busy;

endmodule
